// File: rtl/wishbone_arbiter_pkg.sv
// Shared types for the Wishbone round-robin arbiter: FSM state encoding and
// the grant-index width helper used by every file in the slice.
package wishbone_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      ABORT = 2'd2
   } arb_state_t;

   function automatic int gnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wishbone_arbiter_if.sv
// Wishbone bundle around the arbiter: the master-facing side (m_*) and the
// single shared slave port (s_*).
interface wishbone_arbiter_if #(
   parameter int num_masters = 2,
   parameter int adr_width   = 8,
   parameter int dat_width   = 8,
   parameter int sel_width   = 8
);
   logic [num_masters-1:0]           m_cyc;
   logic [num_masters-1:0]           m_stb;
   logic [num_masters-1:0]           m_we;
   logic [num_masters*adr_width-1:0] m_adr;
   logic [num_masters*dat_width-1:0] m_datwr;
   logic [num_masters*sel_width-1:0] m_sel;
   logic [num_masters-1:0]           m_ack;
   logic [num_masters-1:0]           m_err;
   logic [dat_width-1:0]             m_datrd;

   logic                             s_cyc;
   logic                             s_stb;
   logic                             s_we;
   logic [adr_width-1:0]             s_adr;
   logic [dat_width-1:0]             s_datwr;
   logic [sel_width-1:0]             s_sel;
   logic [dat_width-1:0]             s_datrd;
   logic                             s_ack;

   // Arbiter acting as the slave seen by all requesting masters.
   modport slave (
      input  m_cyc, m_stb, m_we, m_adr, m_datwr, m_sel,
      output m_ack, m_err, m_datrd
   );

   // Arbiter acting as the single master of the shared slave port.
   modport master (
      output s_cyc, s_stb, s_we, s_adr, s_datwr, s_sel,
      input  s_datrd, s_ack
   );
endinterface

// File: rtl/wishbone_arbiter_rr_picker.sv
// Combinational round-robin pick: first requester strictly after `last`,
// wrapping around, so the previous owner is considered only when alone.
module rr_picker
   import wishbone_arb_pkg::*;
#(
   parameter int num_masters = 2,
   parameter int gw          = gnt_width(num_masters)
) (
   input  logic [num_masters-1:0] req,
   input  logic [gw-1:0]          last,
   output logic                   valid,
   output logic [gw-1:0]          idx
);

   // Scan from the farthest offset down so the nearest requester wins.
   always_comb begin
      int cand;
      cand  = 0;
      valid = 1'b0;
      idx   = {gw{1'b0}};
      for (int k = num_masters; k >= 1; k--) begin
         cand = (int'(last) + k) % num_masters;
         if (req[cand]) begin
            valid = 1'b1;
            idx   = gw'(cand);
         end else begin
            valid = valid;
         end
      end
   end

endmodule

// File: rtl/wishbone_arbiter.sv
// Round-robin arbiter sharing one classic Wishbone slave between several
// masters, granting whole cyc-framed cycles with a strobe watchdog abort.
module wishbone_arbiter
   import wishbone_arb_pkg::*;
#(
   parameter int num_masters    = 2,
   parameter int adr_width      = 8,
   parameter int dat_width      = 8,
   parameter int sel_width      = 8,
   parameter int timeout_cycles = 16
) (
   input  logic                               clk,
   input  logic                               rst,
   wishbone_arbiter_if.slave                  mbus,
   wishbone_arbiter_if.master                 sbus,
   output logic [gnt_width(num_masters)-1:0]  gnt
);

   localparam int gw = gnt_width(num_masters);
   localparam int ww = $clog2(timeout_cycles);
   localparam logic [num_masters-1:0] one_lsb = num_masters'(1);
   localparam logic [ww-1:0]          wd_max  = ww'(timeout_cycles - 1);

   arb_state_t             state_r, state_s;
   logic [gw-1:0]          gnt_r, gnt_s;
   logic [gw-1:0]          last_r, last_s;
   logic [ww-1:0]          wd_cnt_r, wd_cnt_s;
   logic [num_masters-1:0] err_r, err_s;
   logic                   pick_valid_s;
   logic [gw-1:0]          pick_idx_s;
   logic                   busy_s;
   logic                   cyc_own_s;
   logic                   stb_own_s;

   rr_picker #(.num_masters(num_masters), .gw(gw)) u_picker (
      .req   (mbus.m_cyc),
      .last  (last_r),
      .valid (pick_valid_s),
      .idx   (pick_idx_s)
   );

   assign busy_s    = (state_r == BUSY);
   assign cyc_own_s = mbus.m_cyc[gnt_r];
   assign stb_own_s = busy_s & mbus.m_stb[gnt_r];

   // Granted master is steered straight onto the slave from the registered grant.
   assign sbus.s_cyc   = busy_s & cyc_own_s;
   assign sbus.s_stb   = stb_own_s;
   assign sbus.s_we    = busy_s & mbus.m_we[gnt_r];
   assign sbus.s_adr   = busy_s ? mbus.m_adr[int'(gnt_r)*adr_width +: adr_width]
                                : {adr_width{1'b0}};
   assign sbus.s_datwr = busy_s ? mbus.m_datwr[int'(gnt_r)*dat_width +: dat_width]
                                : {dat_width{1'b0}};
   assign sbus.s_sel   = busy_s ? mbus.m_sel[int'(gnt_r)*sel_width +: sel_width]
                                : {sel_width{1'b0}};

   assign mbus.m_ack   = (busy_s && sbus.s_ack) ? (one_lsb << gnt_r)
                                                : {num_masters{1'b0}};
   assign mbus.m_err   = err_r;
   assign mbus.m_datrd = sbus.s_datrd;
   assign gnt          = gnt_r;

   // Next-state, grant and watchdog decisions.
   always_comb begin
      state_s  = state_r;
      gnt_s    = gnt_r;
      last_s   = last_r;
      wd_cnt_s = {ww{1'b0}};
      err_s    = {num_masters{1'b0}};
      case (state_r)
         IDLE: begin
            if (pick_valid_s) begin
               state_s = BUSY;
               gnt_s   = pick_idx_s;
               last_s  = pick_idx_s;
            end else begin
               state_s = IDLE;
            end
         end
         BUSY, ABORT: begin
            if (!cyc_own_s) begin
               // Owner released: hand over without an idle cycle if anyone waits.
               if (pick_valid_s) begin
                  state_s = BUSY;
                  gnt_s   = pick_idx_s;
                  last_s  = pick_idx_s;
               end else begin
                  state_s = IDLE;
               end
            end else if (stb_own_s && !sbus.s_ack) begin
               if (wd_cnt_r == wd_max) begin
                  state_s = ABORT;
                  err_s   = one_lsb << gnt_r;
               end else begin
                  wd_cnt_s = wd_cnt_r + ww'(1);
               end
            end else begin
               wd_cnt_s = {ww{1'b0}};
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, grant, watchdog and error-pulse registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r  <= IDLE;
         gnt_r    <= {gw{1'b0}};
         last_r   <= gw'(num_masters - 1);
         wd_cnt_r <= {ww{1'b0}};
         err_r    <= {num_masters{1'b0}};
      end else begin
         state_r  <= state_s;
         gnt_r    <= gnt_s;
         last_r   <= last_s;
         wd_cnt_r <= wd_cnt_s;
         err_r    <= err_s;
      end
   end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed bench for wishbone_arbiter: expected responses are queued as
// stimulus is issued and a negedge monitor checks every ack/err pulse.
module tb_wishbone_arbiter;
   import wishbone_arb_pkg::*;

   typedef struct {
      int         master;
      bit         is_err;
      bit         chk_data;
      logic [7:0] data;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [0:0] gnt;

   exp_t exp_q[$];
   int   tests_run    = 0;
   int   tests_failed = 0;

   logic       ack_en    = 1'b0;
   int         ack_delay = 0;
   logic [7:0] rdata     = 8'h00;
   logic       late_ack  = 1'b0;

   wishbone_arbiter_if #(.num_masters(2), .adr_width(8), .dat_width(8), .sel_width(8)) bus ();

   wishbone_arbiter #(
      .num_masters(2), .adr_width(8), .dat_width(8), .sel_width(8), .timeout_cycles(16)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .mbus (bus),
      .sbus (bus),
      .gnt  (gnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_master(input int m, input logic cyc, input logic stb, input logic we,
                             input logic [7:0] adr, input logic [7:0] dat, input logic [7:0] sel);
      bus.m_cyc[m]           = cyc;
      bus.m_stb[m]           = stb;
      bus.m_we[m]            = we;
      bus.m_adr[m*8 +: 8]    = adr;
      bus.m_datwr[m*8 +: 8]  = dat;
      bus.m_sel[m*8 +: 8]    = sel;
   endtask

   task automatic push_exp(input int m, input bit is_err, input bit chk, input logic [7:0] d);
      exp_t e;
      e.master = m; e.is_err = is_err; e.chk_data = chk; e.data = d;
      exp_q.push_back(e);
   endtask

   // Bounded wait for master m's ack or err; n counts negedges waited.
   task automatic wait_resp(input int m, output int n);
      bit found;
      found = 1'b0;
      n = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clk);
         n++;
         if (bus.m_ack[m] || bus.m_err[m]) found = 1'b1;
      end
      check("resp_wait", 32'(found), 32'd1);
   endtask

   // Slave model: acks after ack_delay strobe cycles, or on demand via late_ack.
   initial begin
      int wcnt;
      wcnt = 0;
      bus.s_ack   = 1'b0;
      bus.s_datrd = 8'h00;
      forever begin
         @(posedge clk);
         #2;
         if (late_ack) begin
            bus.s_ack = 1'b1;
         end else if (bus.s_ack) begin
            bus.s_ack   = 1'b0;
            bus.s_datrd = 8'h00;
            wcnt        = 0;
         end else if (bus.s_cyc && bus.s_stb) begin
            if (ack_en && wcnt == ack_delay) begin
               bus.s_ack   = 1'b1;
               bus.s_datrd = rdata;
            end else begin
               wcnt++;
            end
         end else begin
            wcnt = 0;
         end
      end
   end

   // Scoreboard monitor: every ack/err pulse must match the head of the queue.
   always @(negedge clk) begin
      if (rst && ((|bus.m_ack) || (|bus.m_err))) begin
         if (exp_q.size() == 0) begin
            check("unexpected_resp", 32'({bus.m_ack, bus.m_err}), 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("resp_ack", 32'(bus.m_ack), e.is_err ? 32'd0 : (32'd1 << e.master));
            check("resp_err", 32'(bus.m_err), e.is_err ? (32'd1 << e.master) : 32'd0);
            if (e.chk_data) check("resp_data", 32'(bus.m_datrd), 32'(e.data));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int n;
      rst = 1'b0;
      bus.m_cyc = 2'b00; bus.m_stb = 2'b00; bus.m_we = 2'b00;
      bus.m_adr = 16'h0000; bus.m_datwr = 16'h0000; bus.m_sel = 16'h0000;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_s_cyc", 32'(bus.s_cyc), 32'd0);
      check("rst_s_stb", 32'(bus.s_stb), 32'd0);
      check("rst_s_adr", 32'(bus.s_adr), 32'd0);
      check("rst_m_ack", 32'(bus.m_ack), 32'd0);
      check("rst_m_err", 32'(bus.m_err), 32'd0);
      check("rst_gnt",   32'(gnt),       32'd0);
      rst = 1'b1;

      // Single master 0 read, slave acks with 0xA5
      ack_en = 1'b1; ack_delay = 2; rdata = 8'hA5;
      push_exp(0, 1'b0, 1'b1, 8'hA5);
      step();
      set_master(0, 1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 8'hFF);
      @(negedge clk);
      check("grant_latency_pre", 32'(bus.s_cyc), 32'd0);
      @(negedge clk);
      check("grant_latency_cyc", 32'(bus.s_cyc), 32'd1);
      check("rd_s_adr", 32'(bus.s_adr), 32'h10);
      check("rd_s_we",  32'(bus.s_we),  32'd0);
      check("rd_gnt",   32'(gnt),       32'd0);
      wait_resp(0, n);
      step();
      set_master(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      step();

      // Master 1 write while master 0 idle
      ack_delay = 1;
      push_exp(1, 1'b0, 1'b0, 8'h00);
      step();
      set_master(1, 1'b1, 1'b1, 1'b1, 8'h20, 8'h3C, 8'h01);
      @(negedge clk);
      check("wr_pre_cyc", 32'(bus.s_cyc), 32'd0);
      @(negedge clk);
      check("wr_gnt",     32'(gnt),         32'd1);
      check("wr_s_we",    32'(bus.s_we),    32'd1);
      check("wr_s_adr",   32'(bus.s_adr),   32'h20);
      check("wr_s_datwr", 32'(bus.s_datwr), 32'h3C);
      check("wr_s_sel",   32'(bus.s_sel),   32'h01);
      wait_resp(1, n);
      step();
      set_master(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      step();

      // Both masters request from reset release: grants 0,1,0,1 back to back
      @(negedge clk);
      rst = 1'b0;
      set_master(0, 1'b1, 1'b1, 1'b0, 8'h30, 8'h00, 8'hFF);
      set_master(1, 1'b1, 1'b1, 1'b0, 8'h31, 8'h00, 8'hFF);
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         int e;
         e = k % 2;
         rdata = 8'h50 + 8'(k);
         push_exp(e, 1'b0, 1'b1, 8'h50 + 8'(k));
         wait_resp(e, n);
         check("rr_gnt", 32'(gnt), 32'(e));
         step();
         set_master(e, 1'b0, 1'b0, 1'b0, 8'h30 + 8'(e), 8'h00, 8'hFF);
         step();
         if (k < 2) set_master(e, 1'b1, 1'b1, 1'b0, 8'h30 + 8'(e), 8'h00, 8'hFF);
         @(negedge clk);
         if (k < 3) begin
            check("handover_gnt", 32'(gnt), 32'(1 - e));
            check("handover_cyc", 32'(bus.s_cyc), 32'd1);
         end else begin
            check("final_release_cyc", 32'(bus.s_cyc), 32'd0);
         end
      end
      step();

      // Slave never acks: error pulse after 16 strobe cycles
      ack_en = 1'b0;
      push_exp(0, 1'b1, 1'b0, 8'h00);
      step();
      set_master(0, 1'b1, 1'b1, 1'b0, 8'h44, 8'h00, 8'hFF);
      wait_resp(0, n);
      check("timeout_negedges", 32'(n), 32'd18);
      check("abort_s_cyc", 32'(bus.s_cyc), 32'd0);
      @(negedge clk);
      check("err_single_pulse", 32'(bus.m_err), 32'd0);
      step();
      late_ack = 1'b1;
      @(negedge clk);
      check("late_ack_dropped", 32'(bus.m_ack), 32'd0);
      step();
      late_ack = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_hold_cyc", 32'(bus.s_cyc), 32'd0);
      check("abort_hold_stb", 32'(bus.s_stb), 32'd0);
      step();
      set_master(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      repeat (2) @(negedge clk);
      check("abort_release_cyc", 32'(bus.s_cyc), 32'd0);

      // Reset asserted mid-transfer, then master 0 wins first
      step();
      set_master(1, 1'b1, 1'b1, 1'b1, 8'h66, 8'h77, 8'h0F);
      repeat (3) @(negedge clk);
      check("mid_busy_gnt", 32'(gnt), 32'd1);
      check("mid_busy_cyc", 32'(bus.s_cyc), 32'd1);
      #1;
      rst = 1'b0;
      #1;
      check("mid_rst_s_cyc", 32'(bus.s_cyc), 32'd0);
      check("mid_rst_s_stb", 32'(bus.s_stb), 32'd0);
      check("mid_rst_s_we",  32'(bus.s_we),  32'd0);
      check("mid_rst_s_adr", 32'(bus.s_adr), 32'd0);
      check("mid_rst_m_ack", 32'(bus.m_ack), 32'd0);
      check("mid_rst_m_err", 32'(bus.m_err), 32'd0);
      check("mid_rst_gnt",   32'(gnt),       32'd0);
      set_master(0, 1'b1, 1'b1, 1'b0, 8'h12, 8'h00, 8'hFF);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_gnt", 32'(gnt), 32'd0);
      check("post_rst_cyc", 32'(bus.s_cyc), 32'd1);
      step();
      set_master(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      set_master(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      repeat (3) @(negedge clk);

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
